req_encoder32: RTL
==================

# req_encoder32

Registered 32-to-5 request encoder with a valid/ready output handshake. It is the inverse of the team's 5-to-32 one-hot decoder: it collects up to 32 sticky request lines and presents the index of one pending request at a time on a 5-bit code. A consumer acknowledges each code, and the acknowledged request is cleared. It sits between per-line request sources (interrupt or event lines) and a single consumer that turns the code back into one-hot through the decoder.

## Interface
Parameters:
- N_REQ, 32, number of request lines; fixed, must equal 2**IDX_W
- IDX_W, 5, code width

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  32  request lines; a 1 in any cycle sets the matching pending bit (level or single-cycle pulse)
- A  out  5  encoded index of the presented request; valid only while VALID=1
- VALID  out  1  a code is presented on A
- READY  in  1  consumer accepts A this cycle
- PEND  out  32  registered pending-bit vector, for debug and status
- ANY  out  1  OR-reduction of PEND

## Operation
- **Handshake:** the handshake completes in any cycle where VALID=1 and READY=1.
  - `clr` = one-hot(A) when the handshake completes, else 0.
- **Pending register update:** `cand` = (PEND & ~clr) | REQ; PEND <= `cand` every edge.
  - If REQ sets the same bit that is cleared in the same cycle, the set wins and the bit stays pending.
- **Output stage load rule:** if VALID=0 or READY=1, then VALID <= |`cand` and A <= select(`cand`).
- **Output stability:** while VALID=1 and READY=0, A and VALID hold. Higher-priority arrivals do not preempt the presented code.
- **Presented bit stays set:** the bit shown on A remains set in PEND until it is acknowledged.
- **select(), fixed priority:** the highest set index wins. Bit 31 beats bit 0, matching the decoder's D[31] ordering.
- **No request:** if `cand` is all zeros, VALID <= 0. A holds its last value and is don't-care.
- READY while VALID=0 has no effect.
- **Reset values:**
  - PEND = 0, VALID = 0, A = 5'd0, ANY = 0
  - round-robin pointer LAST = 5'd0 (when the round-robin feature is compiled in)
- **Reset mid-operation:** RST_N low immediately clears every pending request and any code being presented. There is no completion.

## Timing
- **Latency:** REQ asserted in cycle n with the output stage idle gives VALID=1 and the matching A in cycle n+1.
- **Back-to-back throughput:** READY held at 1 gives one code per cycle. The next code is loaded on the same edge as the acknowledge.
- **Re-request of the acknowledged bit:** a bit acknowledged in cycle n and re-requested in cycle n is presented again no earlier than cycle n+1, subject to priority.
- PEND and ANY reflect REQ one cycle after it is sampled.
- There are no combinational paths from REQ or READY to any output.

## Configuration
- REQ_ENC_RR_EN
  - **Defined:** round-robin select.
    - Register LAST <= A on every completed handshake.
    - Search order is LAST-1, LAST-2, …, 0, 31, …, LAST, with wrap-around modulo 32. The first set bit in this order wins.
    - With LAST=0 after reset, the first search order is identical to fixed priority.
  - **Undefined:** fixed priority as above. There is no LAST register.

## Structure
- **Package req_enc_pkg:** holds N_REQ, IDX_W, and the index type (5-bit) and vector type (32-bit).
- **Sub-module prio_enc32to5:**
  - Purely combinational.
  - Inputs: 32-bit vector and a 5-bit start index.
  - Outputs: 5-bit index and a found flag.
  - The top instantiates it once. In the fixed-priority build, start is tied to 0, which gives a search from 31 downward.

## Test plan
- **Reset:** reset asserted mid-stream with PEND=32'hFFFF_FFFF and VALID=1 -> all outputs 0 at once. After release with REQ=0, VALID stays 0.
- **Single pulse:** single-cycle REQ=32'h0000_0400, READY=1 -> next cycle VALID=1, A=10. One cycle later VALID=0 and PEND=0.
- **Fixed-priority ordering:** REQ=32'h8000_0001 for one cycle, READY=1 -> A=31, then A=0, then VALID=0.
- **Stall with arrival:**
  - Presented A=5 with READY=0.
  - REQ bit 20 arrives during the stall.
  - A stays 5 until READY=1. Next cycle A=20.
- **Set/clear collision:** handshake on A=7 in the same cycle as REQ bit 7 -> PEND bit 7 stays 1 and A=7 is presented again.
- **Round-robin (REQ_ENC_RR_EN):** REQ=32'h0000_0111 held, READY=1 -> A sequence 8, 4, 0, 8, 4, 0.

Source files
------------

// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared sizes, types and helpers for the 32-to-5 request encoder.
// Holds N_REQ/IDX_W, the 5-bit index type, the 32-bit vector type and a one-hot helper.
package req_enc_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] vec_t;

    // Inverse of the encoder: index -> one-hot request vector.
    function automatic vec_t onehot(input idx_t i);
        onehot = vec_t'(1) << i;
    endfunction

endpackage

// File: rtl/prio_enc32to5.sv
// prio_enc32to5: combinational 32-to-5 priority search with a movable start point.
// Ports: vec (requests), start (search origin) -> idx (winner), found (any bit set).
// Search order is start-1, start-2, ..., 0, 31, ..., start (mod 32);
// start = 0 degenerates to plain highest-index-wins.
module prio_enc32to5
    import req_enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    idx_t pos;

    // Walk the order backwards so the last hit written is the first in order.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = start - idx_t'(k + 1);
            if (vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder32.sv
// req_encoder32: registered 32-to-5 request encoder with valid/ready output.
// Ports: CLK, RST_N (async low), REQ[31:0] in; A[4:0], VALID out; READY in;
//        PEND[31:0] pending vector, ANY = |PEND.
// Build option REQ_ENC_RR_EN: round-robin select (LAST register) instead of
// fixed highest-index priority.
module req_encoder32
    import req_enc_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    output logic [IDX_W-1:0] A,
    output logic             VALID,
    input  logic             READY,
    output logic [N_REQ-1:0] PEND,
    output logic             ANY
);

    logic             hs;
    logic             load;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;

    assign hs   = VALID & READY;
    assign load = ~VALID | READY;
    assign clr  = hs ? onehot(A) : '0;
    // A new request on the bit being cleared wins over the clear.
    assign cand = (PEND & ~clr) | REQ;

`ifdef REQ_ENC_RR_EN
    logic [IDX_W-1:0] last;

    // Search starts just below the code being acknowledged this edge,
    // so the freshly served line drops to lowest priority immediately.
    assign start = hs ? A : last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last <= '0;
        end else if (hs) begin
            last <= A;
        end
    end
`else
    assign start = '0;
`endif

    prio_enc32to5 u_prio (
        .vec   (cand),
        .start (start),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Output stage reloads only when empty or being drained, so a stalled
    // code is never preempted by later, higher-priority arrivals.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PEND  <= '0;
            VALID <= 1'b0;
            A     <= '0;
        end else begin
            PEND <= cand;
            if (load) begin
                VALID <= sel_found;
                if (sel_found) begin
                    A <= sel_idx;
                end
            end
        end
    end

    assign ANY = |PEND;

endmodule
